// File: rtl/sram_bist_master_if.sv
// sram_bist_master_if: request/acknowledge bus between the BIST master and the SRAM controller
//    req, wr_en, addr, wdata : request side, driven by the master
//    ack, rdata              : acknowledge side, driven by the controller (rdata valid with ack on a read)
interface sram_bist_master_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  req;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rdata;
   modport master (output req, wr_en, addr, wdata, input ack, rdata);
   modport slave  (input req, wr_en, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_bist_master.sv
// sram_bist_master: writes seed ^ replicated-address over an address window, reads it back and compares
//    clk, rst            : clock, asynchronous active-high reset
//    i_start             : 1-cycle pulse, latches i_base/i_last/i_seed when not busy
//    i_base, i_last      : inclusive address window, walked upward modulo 2^ADDR_WIDTH
//    i_seed              : pattern seed
//    bus                 : request/acknowledge bus to the SRAM controller
//    o_busy, o_done      : test running / finished (done held until the next accepted start)
//    o_pass, o_timeout   : clean result / aborted on a missing acknowledge
//    o_err_cnt           : saturating miscompare count
//    o_first_err_addr    : address of the first miscompare
module sram_bist_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 64,
   parameter int ERR_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base,
   input  logic [ADDR_WIDTH-1:0] i_last,
   input  logic [DATA_WIDTH-1:0] i_seed,
   sram_bist_master_if.master    bus,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic                  o_timeout,
   output logic [ERR_WIDTH-1:0]  o_err_cnt,
   output logic [ADDR_WIDTH-1:0] o_first_err_addr
);
   localparam int TW = $clog2(TIMEOUT);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;
   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_base, r_last, r_addr, r_first;
   logic [DATA_WIDTH-1:0] r_seed, w_pat;
   logic [TW-1:0]         r_tmo;
   logic [ERR_WIDTH-1:0]  r_err;
   logic                  r_timeout;
   logic                  w_req, w_hit, w_ack, w_start, w_end;
   // pattern bit i uses address bit i mod ADDR_WIDTH: the address repeated from the LSB up
   for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_pat
      assign w_pat[g] = r_seed[g] ^ r_addr[g % ADDR_WIDTH];
   end
   assign w_req   = (r_state == WR_REQ) || (r_state == RD_REQ);
   // r_tmo counts request cycles already spent; the last allowed cycle aborts and ignores any ack
   assign w_hit   = r_tmo == TW'(TIMEOUT - 1);
   assign w_ack   = bus.ack && !w_hit;
   assign w_start = i_start && ((r_state == IDLE) || (r_state == DONE));
   assign w_end   = r_addr == r_last;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: w_next = i_start ? WR_REQ : r_state;
         WR_REQ:     w_next = w_hit ? DONE : w_ack ? WR_GAP : WR_REQ;
         WR_GAP:     w_next = w_end ? RD_REQ : WR_REQ;
         RD_REQ:     w_next = w_hit ? DONE : w_ack ? RD_GAP : RD_REQ;
         RD_GAP:     w_next = w_end ? DONE : RD_REQ;
         default:    w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_base    <= '0;
         r_last    <= '0;
         r_seed    <= '0;
         r_addr    <= '0;
         r_first   <= '0;
         r_err     <= '0;
         r_tmo     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_tmo <= (w_req && w_next == r_state) ? r_tmo + 1'b1 : '0;
         if (w_start) begin
            r_base    <= i_base;
            r_last    <= i_last;
            r_seed    <= i_seed;
            r_addr    <= i_base;
            r_first   <= '0;
            r_err     <= '0;
            r_timeout <= 1'b0;
         end
         if (w_req && w_hit) r_timeout <= 1'b1;
         if (r_state == RD_REQ && w_ack && bus.rdata != w_pat) begin
            if (r_err == '0) r_first <= r_addr;
            if (!(&r_err)) r_err <= r_err + 1'b1;
         end
         if (r_state == WR_GAP) r_addr <= w_end ? r_base : r_addr + 1'b1;
         if (r_state == RD_GAP && !w_end) r_addr <= r_addr + 1'b1;
      end
   assign bus.req          = w_req;
   assign bus.wr_en        = r_state == WR_REQ;
   assign bus.addr         = r_addr;
   assign bus.wdata        = (r_state == WR_REQ) ? w_pat : '0;
   assign o_busy           = (r_state != IDLE) && (r_state != DONE);
   assign o_done           = r_state == DONE;
   assign o_pass           = o_done && (r_err == '0) && !r_timeout;
   assign o_timeout        = r_timeout;
   assign o_err_cnt        = r_err;
   assign o_first_err_addr = r_first;
endmodule

// File: tb/tb_sram_bist_master.sv
// tb_sram_bist_master: randomized-latency SRAM responder plus a window/pattern reference model
module tb_sram_bist_master;
   localparam int AW = 8, DW = 16, TO = 64, EW = 8;
   logic          clk = 1'b0, rst = 1'b1, i_start = 1'b0;
   logic [AW-1:0] i_base = '0, i_last = '0;
   logic [DW-1:0] i_seed = '0;
   logic          o_busy, o_done, o_pass, o_timeout;
   logic [EW-1:0] o_err_cnt;
   logic [AW-1:0] o_first_err_addr;
   int            checks = 0, errors = 0;
   sram_bist_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   sram_bist_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .ERR_WIDTH(EW)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_base(i_base), .i_last(i_last), .i_seed(i_seed),
      .bus(bus), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
      .o_err_cnt(o_err_cnt), .o_first_err_addr(o_first_err_addr));
   always #5 clk = ~clk;
   // memory responder: ack after 1..4 cycles, optional read faults (1: bit0 stuck-at-0, 2: all bits inverted)
   logic [DW-1:0] mem [256];
   logic [AW-1:0] wlog [$], rlog [$], exp_order [$];
   int            fault_mode = 0, lat = 0, viol = 0, run_len = 0, last_run = 0, exp_err = 0;
   bit            no_ack = 1'b0;
   logic [AW-1:0] exp_first;
   always @(posedge clk) begin
      bus.ack <= 1'b0;
      if (bus.req && !bus.ack && !no_ack) begin
         if (lat == 0) begin
            bus.ack <= 1'b1;
            lat <= $urandom_range(0, 3);
            if (bus.wr_en) begin
               mem[bus.addr] <= bus.wdata;
               wlog.push_back(bus.addr);
            end else begin
               bus.rdata <= fault_mode == 1 ? (mem[bus.addr] & 16'hFFFE) : fault_mode == 2 ? ~mem[bus.addr] : mem[bus.addr];
               rlog.push_back(bus.addr);
            end
         end else lat <= lat - 1;
      end
   end
   // protocol monitor: request fields stable while waiting, no back-to-back request after an ack
   logic          p_req = 1'b0, p_ack = 1'b0, p_wr = 1'b0;
   logic [AW-1:0] p_addr = '0;
   logic [DW-1:0] p_wdata = '0;
   always @(negedge clk) begin
      if (p_req && bus.req && (p_ack || bus.addr !== p_addr || bus.wr_en !== p_wr || bus.wdata !== p_wdata))
         viol <= viol + 1;
      if (bus.req) run_len <= run_len + 1;
      else begin
         if (run_len != 0) last_run <= run_len;
         run_len <= 0;
      end
      p_req <= bus.req; p_ack <= bus.ack; p_wr <= bus.wr_en; p_addr <= bus.addr; p_wdata <= bus.wdata;
   end
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [DW-1:0] s);
      return s ^ (DW'(a) * 16'h0101);
   endfunction
   task automatic model(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [DW-1:0] s, input int fm);
      int a;
      logic [DW-1:0] p, r;
      a = int'(b);
      exp_order = {};
      exp_err = 0;
      exp_first = '0;
      forever begin
         exp_order.push_back(AW'(a));
         if (a == int'(l)) break;
         a = (a + 1) % 256;
      end
      foreach (exp_order[i]) begin
         p = pat(exp_order[i], s);
         r = fm == 1 ? (p & 16'hFFFE) : fm == 2 ? ~p : p;
         if (r != p) begin
            if (exp_err == 0) exp_first = exp_order[i];
            exp_err++;
         end
      end
      if (exp_err > 255) exp_err = 255;
   endtask
   function automatic bit order_ok();
      if (wlog.size() != exp_order.size() || rlog.size() != exp_order.size()) return 1'b0;
      foreach (exp_order[i]) if (wlog[i] != exp_order[i] || rlog[i] != exp_order[i]) return 1'b0;
      return 1'b1;
   endfunction
   task automatic start_test(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [DW-1:0] s);
      @(negedge clk);
      i_base = b; i_last = l; i_seed = s; i_start = 1'b1;
      wlog = {}; rlog = {};
      @(negedge clk);
      i_start = 1'b0;
   endtask
   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (o_done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask
   task automatic test_reset();
      bit [45:0] v;
      @(negedge clk);
      v = {o_busy, o_done, o_pass, o_timeout, o_err_cnt, o_first_err_addr, bus.req, bus.wr_en, bus.addr, bus.wdata};
      checks++; if (v !== '0) begin errors++; $display("FAIL reset_in got %h want 0", v); end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      v = {o_busy, o_done, o_pass, o_timeout, o_err_cnt, o_first_err_addr, bus.req, bus.wr_en, bus.addr, bus.wdata};
      checks++; if (v !== '0) begin errors++; $display("FAIL reset_idle got %h want 0", v); end
   endtask
   task automatic test_full_range();
      bit ok;
      fault_mode = 0;
      model(8'h00, 8'hFF, 16'h0000, 0);
      start_test(8'h00, 8'hFF, 16'h0000);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b want 1", o_busy); end
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_done got no done want done"); end
      checks++; if (o_pass !== 1'b1 || o_err_cnt !== '0) begin errors++; $display("FAIL full_pass got %b/%0d want 1/0", o_pass, o_err_cnt); end
      checks++; if (order_ok() !== 1'b1) begin errors++; $display("FAIL full_order got %0d/%0d accesses want 256/256", wlog.size(), rlog.size()); end
      checks++; if (mem[8'h10] !== 16'h1010) begin errors++; $display("FAIL full_word10 got %h want 1010", mem[8'h10]); end
   endtask
   task automatic test_wrap();
      bit ok;
      fault_mode = 0;
      model(8'hFE, 8'h01, 16'hFACE, 0);
      start_test(8'hFE, 8'h01, 16'hFACE);
      wait_done(ok);
      checks++; if (!ok || o_pass !== 1'b1) begin errors++; $display("FAIL wrap_pass got %b want 1", o_pass); end
      checks++; if (order_ok() !== 1'b1 || exp_order.size() != 4) begin errors++; $display("FAIL wrap_order got %0d writes want 4 (FE FF 00 01)", wlog.size()); end
      checks++; if (mem[8'hFF] !== 16'h0531) begin errors++; $display("FAIL wrap_wordFF got %h want 0531", mem[8'hFF]); end
   endtask
   task automatic test_fault();
      bit ok;
      fault_mode = 1;
      start_test(8'h00, 8'h0F, 16'h0000);
      wait_done(ok);
      fault_mode = 0;
      checks++; if (!ok || o_done !== 1'b1) begin errors++; $display("FAIL fault_done got %b want 1", o_done); end
      checks++; if (o_err_cnt !== 8'd8) begin errors++; $display("FAIL fault_cnt got %0d want 8", o_err_cnt); end
      checks++; if (o_first_err_addr !== 8'h01) begin errors++; $display("FAIL fault_first got %h want 01", o_first_err_addr); end
      checks++; if (o_pass !== 1'b0) begin errors++; $display("FAIL fault_pass got %b want 0", o_pass); end
   endtask
   task automatic test_saturate();
      bit ok;
      fault_mode = 2;
      start_test(8'h00, 8'hFF, 16'h5A5A);
      wait_done(ok);
      fault_mode = 0;
      checks++; if (!ok || o_err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_cnt got %0d want 255", o_err_cnt); end
      checks++; if (o_first_err_addr !== 8'h00 || o_pass !== 1'b0) begin errors++; $display("FAIL sat_first got %h/%b want 00/0", o_first_err_addr, o_pass); end
   endtask
   task automatic test_timeout();
      bit ok;
      no_ack = 1'b1;
      start_test(8'h40, 8'h4F, 16'h1234);
      wait_done(ok);
      repeat (2) @(negedge clk);
      no_ack = 1'b0;
      checks++; if (!ok || o_timeout !== 1'b1 || o_pass !== 1'b0 || o_done !== 1'b1) begin errors++; $display("FAIL tmo_flags got to=%b pass=%b done=%b want 1 0 1", o_timeout, o_pass, o_done); end
      checks++; if (last_run !== TO) begin errors++; $display("FAIL tmo_len got %0d want %0d", last_run, TO); end
   endtask
   task automatic test_start_ignored();
      bit ok;
      logic [DW-1:0] s;
      s = DW'($urandom);
      model(8'h20, 8'h3F, s, 0);
      start_test(8'h20, 8'h3F, s);
      repeat (10) @(negedge clk);
      i_base = 8'h80; i_last = 8'h81; i_seed = ~s; i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      wait_done(ok);
      checks++; if (!ok || o_pass !== 1'b1) begin errors++; $display("FAIL ign_pass got %b want 1", o_pass); end
      checks++; if (order_ok() !== 1'b1) begin errors++; $display("FAIL ign_order got %0d writes want %0d", wlog.size(), exp_order.size()); end
   endtask
   task automatic test_reset_mid();
      bit ok;
      bit [45:0] v;
      start_test(8'h00, 8'hFF, 16'hC3C3);
      repeat (20) @(negedge clk);
      checks++; if (o_busy !== 1'b1 || bus.wr_en !== 1'b1 && bus.req === 1'b1) begin errors++; $display("FAIL rmid_busy got %b want 1", o_busy); end
      #2 rst = 1'b1;
      #1;
      v = {o_busy, o_done, o_pass, o_timeout, o_err_cnt, o_first_err_addr, bus.req, bus.wr_en, bus.addr, bus.wdata};
      checks++; if (v !== '0) begin errors++; $display("FAIL rmid_async got %h want 0", v); end
      @(negedge clk); rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rmid_nodone got done=%b busy=%b want 0 0", o_done, o_busy); end
      model(8'h30, 8'h37, 16'h0F0F, 0);
      start_test(8'h30, 8'h37, 16'h0F0F);
      wait_done(ok);
      checks++; if (!ok || o_pass !== 1'b1 || order_ok() !== 1'b1) begin errors++; $display("FAIL rmid_rerun got pass=%b want 1", o_pass); end
   endtask
   task automatic test_random();
      bit ok;
      logic [AW-1:0] b, l, a;
      logic [DW-1:0] s;
      int fm;
      for (int k = 0; k < 6; k++) begin
         b = AW'($urandom); l = AW'($urandom); s = DW'($urandom); fm = $urandom_range(0, 2);
         model(b, l, s, fm);
         fault_mode = fm;
         start_test(b, l, s);
         wait_done(ok);
         fault_mode = 0;
         a = exp_order[$urandom_range(0, exp_order.size() - 1)];
         checks++; if (!ok || o_pass !== (exp_err == 0) || o_timeout !== 1'b0) begin errors++; $display("FAIL rnd%0d_pass got %b want %b", k, o_pass, exp_err == 0); end
         checks++; if (o_err_cnt !== EW'(exp_err) || o_first_err_addr !== exp_first) begin errors++; $display("FAIL rnd%0d_err got %0d@%h want %0d@%h", k, o_err_cnt, o_first_err_addr, exp_err, exp_first); end
         checks++; if (order_ok() !== 1'b1) begin errors++; $display("FAIL rnd%0d_order got %0d writes want %0d", k, wlog.size(), exp_order.size()); end
         checks++; if (mem[a] !== pat(a, s)) begin errors++; $display("FAIL rnd%0d_mem got %h want %h at %h", k, mem[a], pat(a, s), a); end
      end
   endtask
   task automatic test_protocol();
      checks++; if (viol !== 0) begin errors++; $display("FAIL protocol got %0d violations want 0", viol); end
   endtask
   initial begin
      test_reset();
      test_full_range();
      test_wrap();
      test_fault();
      test_saturate();
      test_timeout();
      test_start_ignored();
      test_reset_mid();
      test_random();
      test_protocol();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
